// File: rtl/rf_spill_fill_pkg.sv
// Shared types for the register-file spill/fill engine.
// Holds the FSM state encoding, op codes and default widths shared with the rf.
package rf_spill_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPILL,
        FILL,
        FILL_LAST,
        DONE
    } sf_state_t;

    localparam logic OP_SPILL = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    localparam int SF_NREGS = 8;
    localparam int SF_DW    = 8;
    localparam int SF_AW    = 3;
    localparam int SF_MAW   = 8;

endpackage

// File: rtl/rf_spill_fill_if.sv
// Bus bundle between the spill/fill engine, the register file and data memory.
// slave: engine side (drives rf/mem ports, busy/done); master: CPU/rf/mem side.
interface rf_spill_fill_if #(
    parameter int DW  = 8,
    parameter int AW  = 3,
    parameter int MAW = 8
);
    logic           start;
    logic           op;
    logic [MAW-1:0] base_addr;
    logic           busy;
    logic           done;
    logic [AW-1:0]  rf_ptr_a;
    logic           rf_we;
    logic [DW-1:0]  rf_di;
    logic [DW-1:0]  rf_do_a;
    logic [MAW-1:0] mem_addr;
    logic           mem_we;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    modport slave (
        input  start, op, base_addr, rf_do_a, mem_rdata,
        output busy, done, rf_ptr_a, rf_we, rf_di,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output start, op, base_addr, rf_do_a, mem_rdata,
        input  busy, done, rf_ptr_a, rf_we, rf_di,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/rf_spill_fill.sv
// Bulk save/restore engine: SPILL copies rf[0..NREGS-1] to mem[base+i], FILL copies back.
// Ports: clk, rst_n (async active-low), bus (rf_spill_fill_if.slave).
module rf_spill_fill
    import rf_spill_fill_pkg::*;
#(
    parameter int NREGS = SF_NREGS,
    parameter int DW    = SF_DW,
    parameter int AW    = SF_AW,
    parameter int MAW   = SF_MAW
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_spill_fill_if.slave bus
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    sf_state_t      state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           op_q, op_d;
    logic [MAW-1:0] base_q, base_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rf_we_q, rf_we_d;
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  rf_ptr_q, rf_ptr_d;
    logic [MAW-1:0] mem_addr_q, mem_addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    base_d  = bus.base_addr;
                    cnt_d   = '0;
                    state_d = (bus.op == OP_FILL) ? FILL : SPILL;
                end
            end
            SPILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FILL_LAST;
            end
            FILL_LAST: state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the next state/count.
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        rf_we_d    = 1'b0;
        mem_we_d   = 1'b0;
        rf_ptr_d   = '0;
        mem_addr_d = '0;
        unique case (state_d)
            SPILL: begin
                rf_ptr_d   = cnt_d;
                mem_addr_d = base_d + MAW'(cnt_d);
                mem_we_d   = 1'b1;
            end
            FILL: begin
                mem_addr_d = base_d + MAW'(cnt_d);
                // Read data lags the address by one cycle, so rf writes trail by one.
                if (cnt_d != '0) begin
                    rf_we_d  = 1'b1;
                    rf_ptr_d = cnt_d - 1'b1;
                end
            end
            FILL_LAST: begin
                rf_we_d  = 1'b1;
                rf_ptr_d = LAST;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_SPILL;
            base_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            rf_ptr_q   <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            base_q     <= base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rf_we_q    <= rf_we_d;
            mem_we_q   <= mem_we_d;
            rf_ptr_q   <= rf_ptr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.rf_ptr_a  = rf_ptr_q;
    assign bus.mem_addr  = mem_addr_q;
    // Data paths pass straight through; gated to zero when not transferring.
    assign bus.mem_wdata = mem_we_q ? bus.rf_do_a : '0;
    assign bus.rf_di     = rf_we_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_rf_spill_fill.sv
// Directed bench for rf_spill_fill with behavioural rf and sync-read data memory.
// Ports: none (top-level testbench).
module tb_rf_spill_fill;

    logic clk;
    logic rst_n;

    rf_spill_fill_if #(.DW(8), .AW(3), .MAW(8)) bus ();

    rf_spill_fill #(.NREGS(8), .DW(8), .AW(3), .MAW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rf  [8];
    logic [7:0] mem [256];
    logic [7:0] mem_rd;

    logic       pk_rf_en;
    logic [2:0] pk_rf_idx;
    logic       pk_mem_en;
    logic [7:0] pk_mem_addr;
    logic [7:0] pk_val;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.rf_we) rf[bus.rf_ptr_a] <= bus.rf_di;
        if (pk_rf_en) rf[pk_rf_idx] <= pk_val;
        if (pk_mem_en) mem[pk_mem_addr] <= pk_val;
        mem_rd <= mem[bus.mem_addr];
    end

    assign bus.rf_do_a   = rf[bus.rf_ptr_a];
    assign bus.mem_rdata = mem_rd;

    int total;
    int bad;
    int both_n;

    always @(negedge clk)
        if (bus.rf_we && bus.mem_we) both_n++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke_rf(input logic [2:0] i, input logic [7:0] v);
        @(negedge clk);
        pk_rf_en = 1'b1; pk_rf_idx = i; pk_val = v;
        @(posedge clk); #1;
        pk_rf_en = 1'b0;
    endtask

    task automatic poke_mem(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        pk_mem_en = 1'b1; pk_mem_addr = a; pk_val = v;
        @(posedge clk); #1;
        pk_mem_en = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, bus.busy, bus.done, bus.rf_we, bus.mem_we,
                bus.rf_ptr_a, bus.rf_di, bus.mem_addr, bus.mem_wdata};
    endfunction

    // Runs one op; cycle 1 is the first cycle after the accept edge.
    task automatic run_op(input logic o, input logic [7:0] b,
                          input int inj_cyc, input int rst_cyc,
                          output int d_cyc, output int busy_n,
                          output int rfw_n, output int rfw_first,
                          output int rfw_last, output int memw_n);
        d_cyc = -1; busy_n = 0; rfw_n = 0;
        rfw_first = -1; rfw_last = -1; memw_n = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.base_addr = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = ~o; bus.base_addr = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_abort_outs", outs(), 32'h0);
                return;
            end
            if (c == inj_cyc) begin
                bus.start = 1'b1; bus.op = 1'b1;
            end
            if (bus.busy) busy_n++;
            if (bus.rf_we) begin
                rfw_n++;
                if (rfw_first < 0) rfw_first = c;
                rfw_last = c;
            end
            if (bus.mem_we) memw_n++;
            if (bus.done) begin
                d_cyc = c;
                break;
            end
        end
    endtask

    int dc, bn, rn, rf1, rfl, mn;
    int dc2, bn2, rn2, rf12, rfl2, mn2;

    initial begin
        total = 0; bad = 0; both_n = 0;
        pk_rf_en = 1'b0; pk_mem_en = 1'b0;
        pk_rf_idx = '0; pk_mem_addr = '0; pk_val = '0;
        bus.start = 1'b0; bus.op = 1'b0; bus.base_addr = '0;
        rst_n = 1'b0;
        #1;
        check("reset_outs", outs(), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", outs(), 32'h0);

        // 1: SPILL rf=0x10.. to 0x40
        for (int i = 0; i < 8; i++) poke_rf(3'(i), 8'(8'h10 + i));
        run_op(1'b0, 8'h40, 0, 0, dc, bn, rn, rf1, rfl, mn);
        check("t1_done_cyc", 32'(dc), 32'd9);
        check("t1_busy_n", 32'(bn), 32'd9);
        check("t1_rfw_n", 32'(rn), 32'd0);
        check("t1_memw_n", 32'(mn), 32'd8);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            check("t1_mem", 32'(mem[8'h40 + i]), 32'(8'h10 + i));

        // 2: FILL from 0x80
        for (int i = 0; i < 8; i++) poke_mem(8'(8'h80 + i), 8'(8'hA0 + i));
        run_op(1'b1, 8'h80, 0, 0, dc, bn, rn, rf1, rfl, mn);
        check("t2_done_cyc", 32'(dc), 32'd10);
        check("t2_busy_n", 32'(bn), 32'd10);
        check("t2_rfw_n", 32'(rn), 32'd8);
        check("t2_rfw_first", 32'(rf1), 32'd2);
        check("t2_rfw_last", 32'(rfl), 32'd9);
        check("t2_memw_n", 32'(mn), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            check("t2_rf", 32'(rf[i]), 32'(8'hA0 + i));

        // 3: SPILL at 0xFC wraps to 0x00..0x03
        poke_mem(8'hFB, 8'h5A);
        poke_mem(8'h04, 8'h5A);
        run_op(1'b0, 8'hFC, 0, 0, dc, bn, rn, rf1, rfl, mn);
        check("t3_done_cyc", 32'(dc), 32'd9);
        check("t3_memw_n", 32'(mn), 32'd8);
        @(negedge clk);
        check("t3_mem_fc", 32'(mem[8'hFC]), 32'hA0);
        check("t3_mem_ff", 32'(mem[8'hFF]), 32'hA3);
        check("t3_mem_00", 32'(mem[8'h00]), 32'hA4);
        check("t3_mem_03", 32'(mem[8'h03]), 32'hA7);
        check("t3_mem_fb", 32'(mem[8'hFB]), 32'h5A);
        check("t3_mem_04", 32'(mem[8'h04]), 32'h5A);

        // 4: start/op=FILL pulsed mid-SPILL is ignored
        run_op(1'b0, 8'h60, 4, 0, dc, bn, rn, rf1, rfl, mn);
        check("t4_done_cyc", 32'(dc), 32'd9);
        check("t4_rfw_n", 32'(rn), 32'd0);
        @(negedge clk);
        check("t4_idle_after", {31'h0, bus.busy}, 32'h0);
        check("t4_mem_60", 32'(mem[8'h60]), 32'hA0);
        check("t4_mem_67", 32'(mem[8'h67]), 32'hA7);
        check("t4_rf_0", 32'(rf[0]), 32'hA0);

        // 5: reset during SPILL at cnt=3
        for (int i = 0; i < 8; i++) poke_rf(3'(i), 8'(8'h50 + i));
        run_op(1'b0, 8'h40, 0, 4, dc, bn, rn, rf1, rfl, mn);
        repeat (2) @(negedge clk);
        check("t5_rst_hold", outs(), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_idle", outs(), 32'h0);
        for (int i = 0; i < 3; i++)
            check("t5_mem_new", 32'(mem[8'h40 + i]), 32'(8'h50 + i));
        for (int i = 3; i < 8; i++)
            check("t5_mem_old", 32'(mem[8'h40 + i]), 32'(8'h10 + i));

        // 6: back-to-back SPILL then FILL of the same base
        run_op(1'b0, 8'h20, 0, 0, dc, bn, rn, rf1, rfl, mn);
        run_op(1'b1, 8'h20, 0, 0, dc2, bn2, rn2, rf12, rfl2, mn2);
        check("t6_spill_done", 32'(dc), 32'd9);
        check("t6_fill_done", 32'(dc2), 32'd10);
        check("t6_fill_rfw", 32'(rn2), 32'd8);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("t6_mem", 32'(mem[8'h20 + i]), 32'(8'h50 + i));
            check("t6_rf", 32'(rf[i]), 32'(8'h50 + i));
        end

        check("no_dual_we", 32'(both_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
